parity_gen_fsm: RTL and testbench

//  - Moore FSM that classifies each sampled input word by the parity of its set bits.
//  - Drives one-hot odd/even flags one clock after sampling.
//  - Standalone leaf block for parity tagging of small data words.
//  - Optional build adds running parity across successive words.

---
 rtl/parity_gen_fsm.sv | 57 +++++
 tb/tb_parity_gen_fsm.sv | 121 ++++++++++++
 2 files changed

// File: rtl/parity_gen_fsm.sv
// Moore FSM that tags each sampled word as odd or even parity, with outputs registered one clock after sampling.
// Optional macro PARITY_ACCUM_EN: track the running parity of every word sampled since reset instead.
module parity_gen_fsm #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] x,
   output logic             odd,
   output logic             even
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      EVEN    = 2'b01,
      ODD     = 2'b10,
      ILLEGAL = 2'b11
   } state_t;

   state_t state_q, state_d;
   logic   odd_q, odd_d;
   logic   even_q, even_d;
   logic   p;

   // The flags are computed from the next state so that the flag flops always match the state flop.
   always_comb begin
      p       = ^x;
      state_d = IDLE;
      case (state_q)
         IDLE, EVEN: state_d = p ? ODD : EVEN;
`ifdef PARITY_ACCUM_EN
         ODD:        state_d = p ? EVEN : ODD;
`else
         ODD:        state_d = p ? ODD : EVEN;
`endif
         default:    state_d = IDLE;
      endcase
      odd_d  = (state_d == ODD);
      even_d = (state_d == EVEN);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         odd_q   <= 1'b0;
         even_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         odd_q   <= odd_d;
         even_q  <= even_d;
      end
   end

   assign odd  = odd_q;
   assign even = even_q;

endmodule

// File: tb/tb_parity_gen_fsm.sv
// Scoreboard bench for parity_gen_fsm; expected flags are queued when stimulus is driven and compared after the edge.
// Build with +define+PARITY_ACCUM_EN to check the accumulate mode.
module tb_parity_gen_fsm;

   localparam int WIDTH = 3;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] x;
   logic             odd;
   logic             even;

   int checkCount;
   int errorCount;

   // Reference state: 0 = idle, 1 = even, 2 = odd.
   int          modelState;
   logic [1:0]  expQueue[$];
   string       tagQueue[$];
   logic [1:0]  lastExp;

   parity_gen_fsm #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .x    (x),
      .odd  (odd),
      .even (even)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: actual {odd,even}=%b required=%b", tag, observed, expected);
      end
   endtask

   // Advance the reference model by one edge and return the expected {odd,even}.
   function automatic logic [1:0] modelStep(input logic r, input logic [WIDTH-1:0] v);
      logic pv;
      pv = ^v;
      if (!r) modelState = 0;
`ifdef PARITY_ACCUM_EN
      else if (modelState == 2) modelState = pv ? 1 : 2;
`endif
      else modelState = pv ? 2 : 1;
      case (modelState)
         1:       return 2'b01;
         2:       return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   task automatic applyStimulus(input logic r, input logic [WIDTH-1:0] v, input string tag);
      logic [1:0] e;
      string      t;
      @(negedge clk);
      rst = r;
      x   = v;
      e   = modelStep(r, v);
      expQueue.push_back(e);
      tagQueue.push_back(tag);
      @(posedge clk);
      #1;
      e = expQueue.pop_front();
      t = tagQueue.pop_front();
      lastExp = e;
      checkOutput(t, {odd, even}, e);
      checkOutput({t, "_excl"}, {1'b0, odd & even}, 2'b00);
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      modelState = 0;
      rst = 1'b0;
      x   = '0;

      applyStimulus(1'b0, 3'd7, "reset0");
      applyStimulus(1'b0, 3'd7, "reset1");
      applyStimulus(1'b1, 3'd0, "release");

      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, 3'(i), $sformatf("sweep_x%0d", i));

      // A mid-cycle change of x must not reach the flags before the next edge.
      applyStimulus(1'b1, 3'd5, "pre_toggle");
      @(negedge clk);
      x = 3'd7;
      #2;
      checkOutput("midcycle_hold", {odd, even}, lastExp);
      x = 3'd6;
      expQueue.push_back(modelStep(1'b1, 3'd6));
      tagQueue.push_back("post_toggle");
      #2;
      checkOutput("midcycle_hold2", {odd, even}, lastExp);
      @(posedge clk);
      #1;
      checkOutput(tagQueue.pop_front(), {odd, even}, expQueue.pop_front());

      applyStimulus(1'b1, 3'd1, "to_odd");
      applyStimulus(1'b0, 3'd7, "reset_mid");
      applyStimulus(1'b1, 3'd3, "release_mid");

      for (int i = 0; i < 40; i++)
         applyStimulus(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)), $sformatf("rand%0d", i));

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
